// File: rtl/uart_pkg.sv
// Shared UART constants and small helpers used by the UART datapath blocks.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_DROP_CNT_W    = 8;

  // Saturating increment for the dropped-byte counter.
  function automatic logic [UART_DROP_CNT_W-1:0] drop_sat_inc(
    input logic [UART_DROP_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; occupancy tracking decides what is valid, and
  // leaving it out keeps the array mappable to plain flops or LUT-RAM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind uart_rx with sticky overflow and drop counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = UART_DATA_W,
  parameter  int DEPTH  = UART_RX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          rx_data_i,
  input  logic                       rx_done_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [ADDR_W:0]            count_o,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic [UART_DROP_CNT_W-1:0] drop_cnt_o,
  input  logic                       ovf_clr_i
);

  localparam logic [ADDR_W:0]            CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]            CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]          PTR_ONE   = ADDR_W'(1);
  localparam logic [UART_DROP_CNT_W-1:0] DROP_ONE  = UART_DROP_CNT_W'(1);

  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]            count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic [UART_DROP_CNT_W-1:0] drop_q, drop_d;
  logic [DATA_W-1:0]          rd_data;
  logic                       push, pop, drop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CNT_DEPTH);
  assign pop     = valid_o & ready_i;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push    = rx_done_i & (~full_o | pop);
  assign drop    = rx_done_i & full_o & ~pop;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (rx_data_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A drop in the clear cycle wins and restarts the count at one.
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = ovf_clr_i ? DROP_ONE : drop_sat_inc(drop_q);
    end else if (ovf_clr_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Gate the unreset storage so data_o reads zero whenever nothing is buffered.
  assign data_o     = valid_o ? rd_data : '0;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule
